id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- Pipeline register between the decode stage and the combinational EX stage.
- Captures decoded operands, addresses and control each cycle.
- Supports stall (hold) and flush (bubble) from the pipeline controller.
- On flush, inserts a canonical NOP so that EX produces no register write, no jump and no memory write.

Parameters:
- NOP_INST, 32'h0000_0013, instruction word loaded on reset/flush (ADDI x0,x0,0).
- RST_ADDR, 32'h0000_0000, inst_addr_o value on reset/flush.
- CNT_W, 32, perf counter width (only used with ID_EX_PERF_CNT_EN).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_i  in  32  decoded instruction word.
- inst_addr_i  in  32  PC of instruction.
- op1_i  in  32  ALU operand 1.
- op2_i  in  32  ALU operand 2.
- rd_addr_i  in  5  destination register.
- reg_wen_i  in  1  register write enable.
- base_addr_i  in  32  branch/jump/mem base address.
- addr_offset_i  in  32  branch/jump/mem offset.
- valid_i  in  1  upstream slot holds a real instruction.
- hold_i  in  1  stall: keep current contents.
- flush_i  in  1  kill: load NOP (driven by EX jump_en via ctrl).
- inst_o, inst_addr_o, op1_o, op2_o, base_addr_o, addr_offset_o  out  32 each  registered copies to EX.
- rd_addr_o  out  5  registered rd.
- reg_wen_o  out  1  registered write enable.
- valid_o  out  1  EX slot holds a real instruction.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values (asserted immediately, independent of clk):
  - inst_o=NOP_INST, inst_addr_o=RST_ADDR.
  - op1_o, op2_o, base_addr_o, addr_offset_o = 0.
  - rd_addr_o=0, reg_wen_o=0, valid_o=0.
- Per rising edge, first matching rule wins:
  - (1) flush_i=1: load NOP state (same values as reset). This applies even if hold_i=1, because a wrong-path instruction must never stall in EX.
  - (2) hold_i=1: all outputs keep their previous values, including valid_o.
  - (3) otherwise: every *_o takes its *_i value, and valid_o=valid_i.
- Latency: exactly 1 cycle from inputs to outputs. No combinational path from input to output.
- valid_i=0 in the load case: data fields are still captured as presented. Upstream supplies the NOP encoding for bubbles. reg_wen_o is forced to 0 whenever valid_i=0.
- Reset deasserting mid-hold: the first post-reset edge follows the normal priority rules. No state survives reset.
- rd_addr_i=0 with reg_wen_i=1 passes through unchanged; x0 suppression is the register file's job.
- No state machine beyond the register itself. Every flop is updated by the single priority rule above.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined:
  - Adds outputs flush_cnt_o[CNT_W-1:0] and stall_cnt_o[CNT_W-1:0], both reset to 0.
  - flush_cnt_o increments on every edge with flush_i=1.
  - stall_cnt_o increments on every edge with hold_i=1 and flush_i=0.
  - Both counters wrap modulo 2^CNT_W without saturation.
- When undefined: these ports and their flops do not exist, and all other behaviour is identical.

Decomposition:
- Shared defines header (existing one), holds:
  - INST_NOP = 32'h0000_0013.
  - ZERO_WORD = 32'h0.
  - ZERO_REG = 5'h0.
  - Width macros for data (32) and register address (5).
- Sub-module pipe_dff, one per field:
  - Parameters: width and default value.
  - Ports: clk, rst_n, hold, flush, d, q.
  - Priority: reset > flush (load default) > hold > load d.
- id_ex_pipe instantiates pipe_dff per field, plus the valid/reg_wen gating and the optional counters.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with nonzero inputs -> outputs immediately become inst_o=32'h13, all others 0, valid_o=0.
- Pass-through: inst_i=32'h00500093, op1_i=0, op2_i=5, rd_addr_i=1, reg_wen_i=1, valid_i=1 -> next edge outputs equal inputs, valid_o=1.
- Hold: hold_i=1 for 3 edges while inputs change to 32'h00a00113 -> outputs stay 32'h00500093 for all 3 edges, then update on the 4th edge after hold_i drops.
- Flush vs hold: flush_i=1 and hold_i=1 on the same edge -> NOP loaded (inst_o=32'h13, reg_wen_o=0, valid_o=0).
- Invalid slot: valid_i=0, reg_wen_i=1, rd_addr_i=3 -> reg_wen_o=0, valid_o=0, rd_addr_o=3.
- ID_EX_PERF_CNT_EN build:
  - CNT_W=4, 17 flush edges -> flush_cnt_o=1 (wrapped).
  - 2 edges with hold+flush -> stall_cnt_o unchanged.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// Shared constants for the ID/EX pipeline register slice.
package id_ex_pipe_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [DATA_W-1:0]     INST_NOP  = 32'h0000_0013;
  localparam logic [DATA_W-1:0]     ZERO_WORD = '0;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG  = '0;

endpackage

// File: rtl/pipe_dff.sv
// Single pipeline field register.
// Priority: async reset > flush (load default) > hold > load d.
module pipe_dff #(
  parameter int unsigned     W   = 32,
  parameter logic [W-1:0]    DEF = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Field register with flush/hold priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= DEF;
    end else if (flush) begin
      q <= DEF;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures decode outputs for the EX stage,
// supports stall (hold) and flush (NOP bubble insertion).
// Optional macro ID_EX_PERF_CNT_EN adds flush/stall event counters.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter logic [31:0]  NOP_INST = INST_NOP,
  parameter logic [31:0]  RST_ADDR = 32'h0000_0000,
  parameter int unsigned  CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     inst_i,
  input  logic [DATA_W-1:0]     inst_addr_i,
  input  logic [DATA_W-1:0]     op1_i,
  input  logic [DATA_W-1:0]     op2_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  reg_wen_i,
  input  logic [DATA_W-1:0]     base_addr_i,
  input  logic [DATA_W-1:0]     addr_offset_i,
  input  logic                  valid_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  output logic [DATA_W-1:0]     inst_o,
  output logic [DATA_W-1:0]     inst_addr_o,
  output logic [DATA_W-1:0]     op1_o,
  output logic [DATA_W-1:0]     op2_o,
  output logic [DATA_W-1:0]     base_addr_o,
  output logic [DATA_W-1:0]     addr_offset_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  reg_wen_o,
  output logic                  valid_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic [CNT_W-1:0]      stall_cnt_o
`endif
);

  logic reg_wen_gated;

  // An empty slot must never write the register file
  always_comb begin
    reg_wen_gated = reg_wen_i & valid_i;
  end

  pipe_dff #(.W(DATA_W), .DEF(NOP_INST)) u_inst (
    .clk(clk), .rst_n(rst_n), .hold(hold_i), .flush(flush_i),
    .d(inst_i), .q(inst_o)
  );

  pipe_dff #(.W(DATA_W), .DEF(RST_ADDR)) u_inst_addr (
    .clk(clk), .rst_n(rst_n), .hold(hold_i), .flush(flush_i),
    .d(inst_addr_i), .q(inst_addr_o)
  );

  pipe_dff #(.W(DATA_W), .DEF(ZERO_WORD)) u_op1 (
    .clk(clk), .rst_n(rst_n), .hold(hold_i), .flush(flush_i),
    .d(op1_i), .q(op1_o)
  );

  pipe_dff #(.W(DATA_W), .DEF(ZERO_WORD)) u_op2 (
    .clk(clk), .rst_n(rst_n), .hold(hold_i), .flush(flush_i),
    .d(op2_i), .q(op2_o)
  );

  pipe_dff #(.W(DATA_W), .DEF(ZERO_WORD)) u_base_addr (
    .clk(clk), .rst_n(rst_n), .hold(hold_i), .flush(flush_i),
    .d(base_addr_i), .q(base_addr_o)
  );

  pipe_dff #(.W(DATA_W), .DEF(ZERO_WORD)) u_addr_offset (
    .clk(clk), .rst_n(rst_n), .hold(hold_i), .flush(flush_i),
    .d(addr_offset_i), .q(addr_offset_o)
  );

  pipe_dff #(.W(REG_ADDR_W), .DEF(ZERO_REG)) u_rd_addr (
    .clk(clk), .rst_n(rst_n), .hold(hold_i), .flush(flush_i),
    .d(rd_addr_i), .q(rd_addr_o)
  );

  pipe_dff #(.W(1), .DEF(1'b0)) u_reg_wen (
    .clk(clk), .rst_n(rst_n), .hold(hold_i), .flush(flush_i),
    .d(reg_wen_gated), .q(reg_wen_o)
  );

  pipe_dff #(.W(1), .DEF(1'b0)) u_valid (
    .clk(clk), .rst_n(rst_n), .hold(hold_i), .flush(flush_i),
    .d(valid_i), .q(valid_o)
  );

`ifdef ID_EX_PERF_CNT_EN
  // Event counters; a stall only counts when it was not overridden by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else if (flush_i) begin
      flush_cnt_o <= flush_cnt_o + 1'b1;
    end else if (hold_i) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`else
  // No performance counters in this build
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe.
// Counter checks run only when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i, base_addr_i, addr_offset_i;
  logic [4:0]  rd_addr_i;
  logic        reg_wen_i, valid_i, hold_i, flush_i;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, base_addr_o, addr_offset_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o, valid_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [3:0]  flush_cnt_o, stall_cnt_o;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(
    .NOP_INST(32'h0000_0013),
    .RST_ADDR(32'h0000_0000),
    .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .op1_i(op1_i), .op2_i(op2_i),
    .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
    .base_addr_i(base_addr_i), .addr_offset_i(addr_offset_i),
    .valid_i(valid_i), .hold_i(hold_i), .flush_i(flush_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op1_o(op1_o), .op2_o(op2_o),
    .base_addr_o(base_addr_o), .addr_offset_o(addr_offset_o),
    .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o), .valid_o(valid_o)
`ifdef ID_EX_PERF_CNT_EN
    , .flush_cnt_o(flush_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic wen, input logic vld,
                       input logic [31:0] base, input logic [31:0] off);
    inst_i = inst; inst_addr_i = addr; op1_i = a; op2_i = b;
    rd_addr_i = rd; reg_wen_i = wen; valid_i = vld;
    base_addr_i = base; addr_offset_i = off;
  endtask

  task automatic check_nop(input string tag);
    check({tag, "_inst"},  inst_o,        32'h13);
    check({tag, "_addr"},  inst_addr_o,   32'h0);
    check({tag, "_op1"},   op1_o,         32'h0);
    check({tag, "_op2"},   op2_o,         32'h0);
    check({tag, "_base"},  base_addr_o,   32'h0);
    check({tag, "_off"},   addr_offset_o, 32'h0);
    check({tag, "_rd"},    {27'd0, rd_addr_o}, 32'h0);
    check({tag, "_wen"},   {31'd0, reg_wen_o}, 32'h0);
    check({tag, "_valid"}, {31'd0, valid_o},   32'h0);
  endtask

  initial begin
    rst_n = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    check_nop("rst_init");
    rst_n = 1'b1;

    // Load a nonzero slot, then reset asynchronously mid-cycle
    drive(32'hdeadbeef, 32'h40, 32'h11, 32'h22, 5'd7, 1'b1, 1'b1, 32'h33, 32'h44);
    tick();
    check("pre_rst_inst", inst_o, 32'hdeadbeef);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_nop("rst_async");
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through
    drive(32'h00500093, 32'h100, 32'h0, 32'h5, 5'd1, 1'b1, 1'b1, 32'h200, 32'h8);
    tick();
    check("pt_inst",  inst_o,        32'h00500093);
    check("pt_addr",  inst_addr_o,   32'h100);
    check("pt_op1",   op1_o,         32'h0);
    check("pt_op2",   op2_o,         32'h5);
    check("pt_base",  base_addr_o,   32'h200);
    check("pt_off",   addr_offset_o, 32'h8);
    check("pt_rd",    {27'd0, rd_addr_o}, 32'd1);
    check("pt_wen",   {31'd0, reg_wen_o}, 32'd1);
    check("pt_valid", {31'd0, valid_o},   32'd1);

    // Hold for three edges while inputs change
    hold_i = 1'b1;
    drive(32'h00a00113, 32'h104, 32'h0, 32'ha, 5'd2, 1'b1, 1'b0, 32'h300, 32'hc);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_inst",  inst_o,            32'h00500093);
      check("hold_op2",   op2_o,             32'h5);
      check("hold_rd",    {27'd0, rd_addr_o}, 32'd1);
      check("hold_valid", {31'd0, valid_o},   32'd1);
    end
    hold_i = 1'b0;
    valid_i = 1'b1;
    tick();
    check("rel_inst", inst_o,            32'h00a00113);
    check("rel_addr", inst_addr_o,       32'h104);
    check("rel_op2",  op2_o,             32'ha);
    check("rel_rd",   {27'd0, rd_addr_o}, 32'd2);

    // Flush wins over hold
    flush_i = 1'b1; hold_i = 1'b1;
    tick();
    check_nop("flush_hold");
    flush_i = 1'b0; hold_i = 1'b0;

    // Invalid slot: fields captured, write enable suppressed
    drive(32'h13, 32'h108, 32'h9, 32'h8, 5'd3, 1'b1, 1'b0, 32'h1, 32'h2);
    tick();
    check("inv_wen",   {31'd0, reg_wen_o}, 32'd0);
    check("inv_valid", {31'd0, valid_o},   32'd0);
    check("inv_rd",    {27'd0, rd_addr_o}, 32'd3);
    check("inv_op1",   op1_o,             32'h9);

    // x0 destination passes through untouched
    drive(32'h00000033, 32'h10c, 32'h1, 32'h2, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0);
    tick();
    check("x0_wen", {31'd0, reg_wen_o}, 32'd1);
    check("x0_rd",  {27'd0, rd_addr_o}, 32'd0);

`ifdef ID_EX_PERF_CNT_EN
    @(negedge clk); rst_n = 1'b0; #1;
    check("cnt_rst_f", {28'd0, flush_cnt_o}, 32'd0);
    check("cnt_rst_s", {28'd0, stall_cnt_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    flush_i = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check("cnt_flush_wrap", {28'd0, flush_cnt_o}, 32'd1);
    hold_i = 1'b1;
    tick(); tick();
    check("cnt_fh_stall", {28'd0, stall_cnt_o}, 32'd0);
    check("cnt_fh_flush", {28'd0, flush_cnt_o}, 32'd3);
    flush_i = 1'b0;
    tick(); tick(); tick();
    check("cnt_stall", {28'd0, stall_cnt_o}, 32'd3);
    hold_i = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
